// File: rtl/cdb_arbiter.sv
// Result broadcast arbiter: per-producer FIFOs (ALU, LSB) round-robin granted onto a registered CDB.
// Optional statistics outputs (conflict_cnt_o, busy_cnt_o) are enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int ROB_ID_W   = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                rdy_i,
   input  logic                flush_i,
   input  logic                alu_valid_i,
   input  logic [31:0]         alu_res_i,
   input  logic [ROB_ID_W-1:0] alu_rob_id_i,
   input  logic                alu_jump_choice_i,
   input  logic [31:0]         alu_pc_i,
   output logic                alu_ready_o,
   input  logic                lsb_valid_i,
   input  logic [31:0]         lsb_res_i,
   input  logic [ROB_ID_W-1:0] lsb_rob_id_i,
   output logic                lsb_ready_o,
   output logic                cdb_valid_o,
   output logic                cdb_src_o,
   output logic [31:0]         cdb_res_o,
   output logic [ROB_ID_W-1:0] cdb_rob_id_o,
   output logic                cdb_jump_choice_o,
   output logic [31:0]         cdb_pc_o
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [31:0]         conflict_cnt_o,
   output logic [31:0]         busy_cnt_o
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSB = 1'b1;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         next_ptr = {PTR_W{1'b0}};
      end else begin
         next_ptr = p + PTR_W'(1);
      end
   endfunction

   logic [31:0]         alu_res_mem_q  [FIFO_DEPTH];
   logic [ROB_ID_W-1:0] alu_id_mem_q   [FIFO_DEPTH];
   logic                alu_jump_mem_q [FIFO_DEPTH];
   logic [31:0]         alu_pc_mem_q   [FIFO_DEPTH];
   logic [31:0]         lsb_res_mem_q  [FIFO_DEPTH];
   logic [ROB_ID_W-1:0] lsb_id_mem_q   [FIFO_DEPTH];

   logic [PTR_W-1:0]    alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
   logic [PTR_W-1:0]    lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
   logic [CNT_W-1:0]    alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
   logic                last_grant_q, last_grant_d;

   logic                cdb_valid_q, cdb_valid_d;
   logic                cdb_src_q, cdb_src_d;
   logic [31:0]         cdb_res_q, cdb_res_d;
   logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
   logic                cdb_jump_q, cdb_jump_d;
   logic [31:0]         cdb_pc_q, cdb_pc_d;

   logic alu_ne_s, lsb_ne_s, alu_push_s, lsb_push_s, grant_alu_s, grant_lsb_s;

   assign alu_ready_o = (alu_cnt_q != CNT_FULL);
   assign lsb_ready_o = (lsb_cnt_q != CNT_FULL);
   assign alu_ne_s    = (alu_cnt_q != {CNT_W{1'b0}});
   assign lsb_ne_s    = (lsb_cnt_q != {CNT_W{1'b0}});
   assign alu_push_s  = rdy_i & alu_valid_i & alu_ready_o;
   assign lsb_push_s  = rdy_i & lsb_valid_i & lsb_ready_o;

   assign cdb_valid_o       = cdb_valid_q;
   assign cdb_src_o         = cdb_src_q;
   assign cdb_res_o         = cdb_res_q;
   assign cdb_rob_id_o      = cdb_rob_id_q;
   assign cdb_jump_choice_o = cdb_jump_q;
   assign cdb_pc_o          = cdb_pc_q;

   // Round-robin grant: contention goes to the source not granted last time
   always_comb begin
      grant_alu_s = 1'b0;
      grant_lsb_s = 1'b0;
      if (rdy_i) begin
         if (alu_ne_s && lsb_ne_s) begin
            if (last_grant_q == SRC_LSB) begin
               grant_alu_s = 1'b1;
            end else begin
               grant_lsb_s = 1'b1;
            end
         end else begin
            grant_alu_s = alu_ne_s;
            grant_lsb_s = lsb_ne_s;
         end
      end else begin
         grant_alu_s = 1'b0;
         grant_lsb_s = 1'b0;
      end
   end

   // Next-state for FIFO bookkeeping and the broadcast register
   always_comb begin
      alu_wr_d     = alu_wr_q;
      alu_rd_d     = alu_rd_q;
      lsb_wr_d     = lsb_wr_q;
      lsb_rd_d     = lsb_rd_q;
      alu_cnt_d    = alu_cnt_q;
      lsb_cnt_d    = lsb_cnt_q;
      last_grant_d = last_grant_q;
      cdb_valid_d  = cdb_valid_q;
      cdb_src_d    = cdb_src_q;
      cdb_res_d    = cdb_res_q;
      cdb_rob_id_d = cdb_rob_id_q;
      cdb_jump_d   = cdb_jump_q;
      cdb_pc_d     = cdb_pc_q;

      if (rdy_i) begin
         if (alu_push_s) begin
            alu_wr_d = next_ptr(alu_wr_q);
         end else begin
            alu_wr_d = alu_wr_q;
         end
         if (lsb_push_s) begin
            lsb_wr_d = next_ptr(lsb_wr_q);
         end else begin
            lsb_wr_d = lsb_wr_q;
         end

         case ({alu_push_s, grant_alu_s})
            2'b10:   alu_cnt_d = alu_cnt_q + CNT_W'(1);
            2'b01:   alu_cnt_d = alu_cnt_q - CNT_W'(1);
            default: alu_cnt_d = alu_cnt_q;
         endcase
         case ({lsb_push_s, grant_lsb_s})
            2'b10:   lsb_cnt_d = lsb_cnt_q + CNT_W'(1);
            2'b01:   lsb_cnt_d = lsb_cnt_q - CNT_W'(1);
            default: lsb_cnt_d = lsb_cnt_q;
         endcase

         if (grant_alu_s) begin
            alu_rd_d     = next_ptr(alu_rd_q);
            last_grant_d = SRC_ALU;
            cdb_valid_d  = 1'b1;
            cdb_src_d    = SRC_ALU;
            cdb_res_d    = alu_res_mem_q[alu_rd_q];
            cdb_rob_id_d = alu_id_mem_q[alu_rd_q];
            cdb_jump_d   = alu_jump_mem_q[alu_rd_q];
            cdb_pc_d     = alu_pc_mem_q[alu_rd_q];
         end else if (grant_lsb_s) begin
            lsb_rd_d     = next_ptr(lsb_rd_q);
            last_grant_d = SRC_LSB;
            cdb_valid_d  = 1'b1;
            cdb_src_d    = SRC_LSB;
            cdb_res_d    = lsb_res_mem_q[lsb_rd_q];
            cdb_rob_id_d = lsb_id_mem_q[lsb_rd_q];
            cdb_jump_d   = 1'b0;
            cdb_pc_d     = 32'h0000_0000;
         end else begin
            cdb_valid_d  = 1'b0;
         end
      end else begin
         cdb_valid_d = cdb_valid_q;
      end
   end

   // Control and broadcast registers; flush clears exactly like reset
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         alu_wr_q     <= {PTR_W{1'b0}};
         alu_rd_q     <= {PTR_W{1'b0}};
         lsb_wr_q     <= {PTR_W{1'b0}};
         lsb_rd_q     <= {PTR_W{1'b0}};
         alu_cnt_q    <= {CNT_W{1'b0}};
         lsb_cnt_q    <= {CNT_W{1'b0}};
         last_grant_q <= SRC_LSB;
         cdb_valid_q  <= 1'b0;
         cdb_src_q    <= 1'b0;
         cdb_res_q    <= 32'h0000_0000;
         cdb_rob_id_q <= {ROB_ID_W{1'b0}};
         cdb_jump_q   <= 1'b0;
         cdb_pc_q     <= 32'h0000_0000;
      end else begin
         alu_wr_q     <= alu_wr_d;
         alu_rd_q     <= alu_rd_d;
         lsb_wr_q     <= lsb_wr_d;
         lsb_rd_q     <= lsb_rd_d;
         alu_cnt_q    <= alu_cnt_d;
         lsb_cnt_q    <= lsb_cnt_d;
         last_grant_q <= last_grant_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_src_q    <= cdb_src_d;
         cdb_res_q    <= cdb_res_d;
         cdb_rob_id_q <= cdb_rob_id_d;
         cdb_jump_q   <= cdb_jump_d;
         cdb_pc_q     <= cdb_pc_d;
      end
   end

   // FIFO payload storage; a push coinciding with reset or flush is dropped
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         if (alu_push_s) begin
            alu_res_mem_q[alu_wr_q]  <= alu_res_i;
            alu_id_mem_q[alu_wr_q]   <= alu_rob_id_i;
            alu_jump_mem_q[alu_wr_q] <= alu_jump_choice_i;
            alu_pc_mem_q[alu_wr_q]   <= alu_pc_i;
         end
         if (lsb_push_s) begin
            lsb_res_mem_q[lsb_wr_q]  <= lsb_res_i;
            lsb_id_mem_q[lsb_wr_q]   <= lsb_rob_id_i;
         end
      end
   end

`ifdef CDB_ARB_STATS_EN
   logic [31:0] conflict_cnt_q, busy_cnt_q;

   assign conflict_cnt_o = conflict_cnt_q;
   assign busy_cnt_o     = busy_cnt_q;

   // Saturating activity counters; survive flush, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         conflict_cnt_q <= 32'h0000_0000;
         busy_cnt_q     <= 32'h0000_0000;
      end else if (rdy_i) begin
         if (alu_ne_s && lsb_ne_s && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
         end
         if (cdb_valid_q && (busy_cnt_q != 32'hFFFF_FFFF)) begin
            busy_cnt_q <= busy_cnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        alu_valid, alu_jump_choice, lsb_valid;
   logic [31:0] alu_res, alu_pc, lsb_res;
   logic [4:0]  alu_rob_id, lsb_rob_id;
   logic        alu_ready, lsb_ready;
   logic        cdb_valid, cdb_src, cdb_jump_choice;
   logic [31:0] cdb_res, cdb_pc;
   logic [4:0]  cdb_rob_id;
`ifdef CDB_ARB_STATS_EN
   logic [31:0] conflict_cnt, busy_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_ID_W(5)) dut (
      .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .flush_i(flush),
      .alu_valid_i(alu_valid), .alu_res_i(alu_res), .alu_rob_id_i(alu_rob_id),
      .alu_jump_choice_i(alu_jump_choice), .alu_pc_i(alu_pc), .alu_ready_o(alu_ready),
      .lsb_valid_i(lsb_valid), .lsb_res_i(lsb_res), .lsb_rob_id_i(lsb_rob_id),
      .lsb_ready_o(lsb_ready),
      .cdb_valid_o(cdb_valid), .cdb_src_o(cdb_src), .cdb_res_o(cdb_res),
      .cdb_rob_id_o(cdb_rob_id), .cdb_jump_choice_o(cdb_jump_choice), .cdb_pc_o(cdb_pc)
`ifdef CDB_ARB_STATS_EN
      , .conflict_cnt_o(conflict_cnt), .busy_cnt_o(busy_cnt)
`endif
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  id;
      logic        j;
      logic [31:0] pc;
   } ent_t;

   ent_t        aq[$];
   ent_t        lq[$];
   ent_t        m_e;
   logic        m_last;
   logic        m_valid, m_src, m_j;
   logic [31:0] m_res, m_pc;
   logic [4:0]  m_id;
   bit          a_take, l_take;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: two queues, arbitration decided on the pre-edge heads
   always @(posedge clk) begin
      if (rst || flush) begin
         aq.delete();
         lq.delete();
         m_last  = 1'b1;
         m_valid = 1'b0; m_src = 1'b0; m_res = 32'h0; m_id = 5'd0; m_j = 1'b0; m_pc = 32'h0;
      end else if (rdy) begin
         a_take = alu_valid && (aq.size() < DEPTH);
         l_take = lsb_valid && (lq.size() < DEPTH);
         if (aq.size() > 0 && (lq.size() == 0 || m_last == 1'b1)) begin
            m_e = aq.pop_front();
            m_valid = 1'b1; m_src = 1'b0; m_res = m_e.res; m_id = m_e.id;
            m_j = m_e.j; m_pc = m_e.pc; m_last = 1'b0;
         end else if (lq.size() > 0) begin
            m_e = lq.pop_front();
            m_valid = 1'b1; m_src = 1'b1; m_res = m_e.res; m_id = m_e.id;
            m_j = 1'b0; m_pc = 32'h0; m_last = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (a_take) aq.push_back('{alu_res, alu_rob_id, alu_jump_choice, alu_pc});
         if (l_take) lq.push_back('{lsb_res, lsb_rob_id, 1'b0, 32'h0});
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_cdb_valid", cdb_valid, m_valid);
         chk("m_cdb_src", cdb_src, m_src);
         chk("m_cdb_res", cdb_res, m_res);
         chk("m_cdb_rob_id", cdb_rob_id, m_id);
         chk("m_cdb_jump", cdb_jump_choice, m_j);
         chk("m_cdb_pc", cdb_pc, m_pc);
         chk("m_alu_ready", alu_ready, aq.size() < DEPTH);
         chk("m_lsb_ready", lsb_ready, lsb_ready_exp());
      end
   end

   function automatic logic lsb_ready_exp();
      return lq.size() < DEPTH;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic av, input logic [31:0] ar, input logic [4:0] ai,
                      input logic aj, input logic [31:0] ap,
                      input logic lv, input logic [31:0] lr, input logic [4:0] li);
      alu_valid = av; alu_res = ar; alu_rob_id = ai; alu_jump_choice = aj; alu_pc = ap;
      lsb_valid = lv; lsb_res = lr; lsb_rob_id = li;
   endtask

   task automatic idle();
      drv(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int  ai, li;
   bit  ra, rl;

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      idle();
      step();
      step();
      rst = 1'b0;
      chk_on = 1'b1;
      chk("reset_valid", cdb_valid, 1'b0);
      chk("reset_res", cdb_res, 32'h0);
      chk("reset_alu_ready", alu_ready, 1'b1);
      chk("reset_lsb_ready", lsb_ready, 1'b1);

      // single ALU push, two-edge latency, one-cycle pulse
      drv(1'b1, 32'h1234, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      step();
      idle();
      chk("t1_not_yet", cdb_valid, 1'b0);
      step();
      chk("t1_valid", cdb_valid, 1'b1);
      chk("t1_src", cdb_src, 1'b0);
      chk("t1_res", cdb_res, 32'h1234);
      chk("t1_id", cdb_rob_id, 5'd3);
      step();
      chk("t1_pulse_end", cdb_valid, 1'b0);
      chk("t1_res_hold", cdb_res, 32'h1234);

      // simultaneous push after reset: ALU first
      do_reset();
      drv(1'b1, 32'h11, 5'd1, 1'b0, 32'h0, 1'b1, 32'h22, 5'd2);
      step();
      idle();
      step();
      chk("t2_first_src", cdb_src, 1'b0);
      chk("t2_first_id", cdb_rob_id, 5'd1);
      step();
      chk("t2_second_src", cdb_src, 1'b1);
      chk("t2_second_id", cdb_rob_id, 5'd2);
      chk("t2_second_valid", cdb_valid, 1'b1);
`ifdef CDB_ARB_STATS_EN
      chk("t2_conflict_cnt", conflict_cnt, 32'd1);
`endif
      step();
      chk("t2_done", cdb_valid, 1'b0);

      // LSB streaming ids 4..7 in order
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h400 + i, 5'(4 + i));
         chk("t3_ready", lsb_ready, 1'b1);
         step();
         if (i > 0) chk("t3_order", cdb_rob_id, 5'(3 + i));
      end
      idle();
      step();
      chk("t3_last", cdb_rob_id, 5'd7);
      chk("t3_last_src", cdb_src, 1'b1);
      step();
      chk("t3_drained", cdb_valid, 1'b0);

      // LSB zeroes jump/pc, ALU forwards them
      do_reset();
      drv(1'b0, 32'h0, 5'd0, 1'b1, 32'h100, 1'b1, 32'h55, 5'd5);
      step();
      idle();
      step();
      chk("t6_lsb_src", cdb_src, 1'b1);
      chk("t6_lsb_jump", cdb_jump_choice, 1'b0);
      chk("t6_lsb_pc", cdb_pc, 32'h0);
      drv(1'b1, 32'h66, 5'd6, 1'b1, 32'h100, 1'b0, 32'h0, 5'd0);
      step();
      idle();
      step();
      chk("t6_alu_jump", cdb_jump_choice, 1'b1);
      chk("t6_alu_pc", cdb_pc, 32'h100);
      chk("t6_alu_id", cdb_rob_id, 5'd6);

      // freeze with rdy=0, then resume the alternation
      do_reset();
      drv(1'b1, 32'h8, 5'd8, 1'b0, 32'h0, 1'b1, 32'hA, 5'd10);
      step();
      drv(1'b1, 32'h9, 5'd9, 1'b0, 32'h0, 1'b1, 32'hB, 5'd11);
      step();
      idle();
      chk("t5_pre_id", cdb_rob_id, 5'd8);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_frozen_valid", cdb_valid, 1'b1);
         chk("t5_frozen_id", cdb_rob_id, 5'd8);
      end
      rdy = 1'b1;
      step();
      chk("t5_resume_l", cdb_rob_id, 5'd10);
      step();
      chk("t5_resume_a", cdb_rob_id, 5'd9);
      step();
      chk("t5_resume_l2", cdb_rob_id, 5'd11);
      step();
      chk("t5_end", cdb_valid, 1'b0);

      // sustained dual traffic with producers holding data until accepted, then flush
      do_reset();
      ai = 0; li = 0;
      for (int i = 0; i < 12; i++) begin
         drv(1'b1, 32'hA00 + ai, 5'(ai), 1'b0, 32'h0, 1'b1, 32'hB00 + li, 5'(16 + li));
         ra = alu_ready;
         rl = lsb_ready;
         step();
         if (ra) ai++;
         if (rl) li++;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      chk("t4_flush_valid", cdb_valid, 1'b0);
      chk("t4_flush_alu_ready", alu_ready, 1'b1);
      chk("t4_flush_lsb_ready", lsb_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_no_stale", cdb_valid, 1'b0);
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
